// File: rtl/carbon_arch_pkg.sv
// Shared definitions for the completion writer: COMP_REC_V1 record layout,
// writer state encoding and a helper that picks the record word for a state.
package carbon_arch_pkg;

   // COMP_REC_V1: four little-endian 32-bit words, 16 bytes per ring slot
   localparam int unsigned COMP_REC_V1_BYTES = 16;
   localparam int unsigned COMP_REC_V1_SHIFT = $clog2(COMP_REC_V1_BYTES);
   localparam int unsigned OFF_TAG           = 0;
   localparam int unsigned OFF_STATUS        = 4;  // {ext_status, status}
   localparam int unsigned OFF_BYTES         = 8;
   localparam int unsigned OFF_RSVD          = 12;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      W0   = 3'd1,
      W1   = 3'd2,
      W2   = 3'd3,
      W3   = 3'd4,
      DONE = 3'd5
   } comp_state_e;

   typedef struct packed {
      logic [31:0] tag;
      logic [15:0] status;
      logic [15:0] ext_status;
      logic [31:0] bytes;
   } comp_rec_t;

   localparam int unsigned COMP_REC_W = $bits(comp_rec_t);

   // Record word written while in the given write state
   function automatic logic [31:0] rec_word(input comp_rec_t r, input comp_state_e s);
      logic [31:0] w;
      w = 32'h0;
      case (s)
         W0:      w = r.tag;
         W1:      w = {r.ext_status, r.status};
         W2:      w = r.bytes;
         default: w = 32'h0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/cai_comp_fifo.sv
// Small synchronous FIFO buffering completions ahead of the record writer.
// Read data is the current head, valid whenever empty_o is low.
module cai_comp_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 96
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic [AW:0]      wr_ptr_d;
   logic [AW:0]      rd_ptr_d;
   logic             do_push;
   logic             do_pop;

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   assign wr_ptr_d = do_push ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
   assign rd_ptr_d = do_pop  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;

   // Pointer update; reset empties the FIFO
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write; contents need no reset since the pointers gate visibility
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/cai_comp_writer.sv
// Completion record writer: buffers completions from the device core and
// writes each as a 16-byte COMP_REC_V1 record into a ring in memory, one
// 32-bit word at a time, then pulses comp_msg and bumps the producer index.
//
// state | meaning
// IDLE  | waiting for a buffered completion and enable
// W0    | writing tag word (slot + 0)
// W1    | writing {ext_status, status} word (slot + 4)
// W2    | writing byte count word (slot + 8)
// W3    | writing reserved zero word (slot + 12)
// DONE  | comp_msg pulse; head completion popped on exit
module cai_comp_writer
   import carbon_arch_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int ADDR_W     = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [ADDR_W-1:0] comp_base,
   input  logic [31:0]       comp_mask,
   input  logic              comp_valid,
   output logic              comp_ready,
   input  logic [31:0]       comp_tag,
   input  logic [15:0]       comp_status,
   input  logic [15:0]       comp_ext_status,
   input  logic [31:0]       comp_bytes,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic              mem_ack,
   output logic              comp_msg,
   output logic [31:0]       comp_idx
);

   comp_state_e       state_q;
   logic [ADDR_W-1:0] slot_q;
   logic [ADDR_W-1:0] slot_d;
   logic              mem_req_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wdata_q;
   logic              comp_msg_q;
   logic [31:0]       comp_idx_q;
   logic [31:0]       comp_idx_d;

   comp_rec_t         in_rec;
   comp_rec_t         head;
   logic [COMP_REC_W-1:0] fifo_rdata;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;

   assign in_rec = '{tag:        comp_tag,
                     status:     comp_status,
                     ext_status: comp_ext_status,
                     bytes:      comp_bytes};
   assign head   = comp_rec_t'(fifo_rdata);

   // Ready never looks at the same-cycle pop, and is held low during reset
   assign comp_ready = ~rst & ~fifo_full;
   assign fifo_push  = comp_valid & comp_ready;
   assign fifo_pop   = (state_q == DONE);

   cai_comp_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (COMP_REC_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .wdata_i (in_rec),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Ring slot for the next record; only sampled on W0 entry
   assign slot_d     = comp_base +
                       (ADDR_W'(comp_idx_q & comp_mask) << COMP_REC_V1_SHIFT);
   assign comp_idx_d = comp_idx_q + 32'd1;

   // Record-writer FSM with registered memory-port and message outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         slot_q      <= '0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         comp_msg_q  <= 1'b0;
         comp_idx_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               comp_msg_q <= 1'b0;
               if (!fifo_empty && enable) begin
                  state_q     <= W0;
                  slot_q      <= slot_d;
                  mem_req_q   <= 1'b1;
                  mem_addr_q  <= slot_d + ADDR_W'(OFF_TAG);
                  mem_wdata_q <= rec_word(head, W0);
               end
            end
            W0: begin
               if (mem_ack) begin
                  state_q     <= W1;
                  mem_addr_q  <= slot_q + ADDR_W'(OFF_STATUS);
                  mem_wdata_q <= rec_word(head, W1);
               end
            end
            W1: begin
               if (mem_ack) begin
                  state_q     <= W2;
                  mem_addr_q  <= slot_q + ADDR_W'(OFF_BYTES);
                  mem_wdata_q <= rec_word(head, W2);
               end
            end
            W2: begin
               if (mem_ack) begin
                  state_q     <= W3;
                  mem_addr_q  <= slot_q + ADDR_W'(OFF_RSVD);
                  mem_wdata_q <= rec_word(head, W3);
               end
            end
            W3: begin
               if (mem_ack) begin
                  state_q    <= DONE;
                  mem_req_q  <= 1'b0;
                  comp_msg_q <= 1'b1;
                  comp_idx_q <= comp_idx_d;
               end
            end
            DONE: begin
               state_q    <= IDLE;
               comp_msg_q <= 1'b0;
            end
            default: begin
               state_q    <= IDLE;
               mem_req_q  <= 1'b0;
               comp_msg_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = 4'hF;
   assign comp_msg  = comp_msg_q;
   assign comp_idx  = comp_idx_q;

endmodule

// File: tb/tb_cai_comp_writer.sv
// Directed bench for cai_comp_writer: zero-wait and stalled memory responder,
// write log captured on the falling edge, hand-computed expectations.
module tb_cai_comp_writer;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [63:0] comp_base;
   logic [31:0] comp_mask;
   logic        comp_valid;
   logic        comp_ready;
   logic [31:0] comp_tag;
   logic [15:0] comp_status;
   logic [15:0] comp_ext_status;
   logic [31:0] comp_bytes;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack;
   logic        comp_msg;
   logic [31:0] comp_idx;

   logic        ack_en;
   logic        stall_w1;

   int          cmp_cnt;
   int          mis_cnt;
   int          msg_cnt;
   logic [63:0] la[$];
   logic [31:0] ld[$];

   cai_comp_writer #(.FIFO_DEPTH(2), .ADDR_W(64)) dut (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable),
      .comp_base       (comp_base),
      .comp_mask       (comp_mask),
      .comp_valid      (comp_valid),
      .comp_ready      (comp_ready),
      .comp_tag        (comp_tag),
      .comp_status     (comp_status),
      .comp_ext_status (comp_ext_status),
      .comp_bytes      (comp_bytes),
      .mem_req         (mem_req),
      .mem_addr        (mem_addr),
      .mem_wdata       (mem_wdata),
      .mem_wstrb       (mem_wstrb),
      .mem_ack         (mem_ack),
      .comp_msg        (comp_msg),
      .comp_idx        (comp_idx)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory responder: immediate ack, optionally withheld on the slot+4 word
   assign mem_ack = mem_req & ack_en & ~(stall_w1 & (mem_addr[3:0] == 4'h4));

   // Write log and message counter
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_req && mem_ack) begin
            la.push_back(mem_addr);
            ld.push_back(mem_wdata);
         end
         if (comp_msg) msg_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      cmp_cnt++;
      if (obs !== exp) begin
         mis_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_wr(input int i, input logic [63:0] a, input logic [31:0] d, input string tag);
      if (i < la.size()) begin
         chk({tag, "_addr"}, la[i], a);
         chk({tag, "_data"}, {32'h0, ld[i]}, {32'h0, d});
      end else begin
         chk({tag, "_missing"}, la.size(), i + 1);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      comp_valid = 1'b0;
      la.delete();
      ld.delete();
      msg_cnt = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic push(input logic [31:0] t, input logic [15:0] s,
                       input logic [15:0] e, input logic [31:0] b);
      int n;
      @(posedge clk); #1;
      comp_tag = t; comp_status = s; comp_ext_status = e; comp_bytes = b;
      comp_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!comp_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("push_timeout", 64'(comp_ready), 64'd1);
      @(posedge clk); #1;
      comp_valid = 1'b0;
   endtask

   task automatic wait_msgs(input int n, input string tag);
      int k;
      k = 0;
      while (msg_cnt < n && k < 500) begin
         @(negedge clk);
         k++;
      end
      repeat (3) @(negedge clk);
      chk(tag, 64'(msg_cnt), 64'(n));
   endtask

   task automatic wait_addr(input logic [63:0] a, input string tag);
      int k;
      logic found;
      k = 0;
      found = 1'b0;
      while (k < 200) begin
         @(negedge clk);
         if (mem_req && mem_addr == a) begin
            found = 1'b1;
            break;
         end
         k++;
      end
      chk(tag, 64'(found), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int m;
      logic seen;
      cmp_cnt = 0; mis_cnt = 0; msg_cnt = 0;
      rst = 1'b0; enable = 1'b0; comp_base = '0; comp_mask = '0;
      comp_valid = 1'b0; comp_tag = '0; comp_status = '0;
      comp_ext_status = '0; comp_bytes = '0;
      ack_en = 1'b1; stall_w1 = 1'b0;

      // Reset state
      #2 rst = 1'b1;
      @(negedge clk);
      chk("rst_ready", 64'(comp_ready), 64'd0);
      chk("rst_req",   64'(mem_req),    64'd0);
      chk("rst_addr",  mem_addr,        64'd0);
      chk("rst_wdata", 64'(mem_wdata),  64'd0);
      chk("rst_msg",   64'(comp_msg),   64'd0);
      chk("rst_idx",   64'(comp_idx),   64'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 64'(comp_ready), 64'd1);

      // Single completion, zero-wait memory, latency
      comp_base = 64'h500; comp_mask = 32'h0; enable = 1'b1;
      push(32'd1, 16'd0, 16'd0, 32'd4);
      k = 0;
      while (k < 50) begin
         @(negedge clk);
         k++;
         if (comp_msg) break;
      end
      chk("latency", 64'(k), 64'd6);
      wait_msgs(1, "t1_msgs");
      chk("t1_nwr", 64'(la.size()), 64'd4);
      chk_wr(0, 64'h500, 32'd1, "t1_w0");
      chk_wr(1, 64'h504, 32'd0, "t1_w1");
      chk_wr(2, 64'h508, 32'd4, "t1_w2");
      chk_wr(3, 64'h50C, 32'd0, "t1_w3");
      chk("t1_idx", 64'(comp_idx), 64'd1);
      chk("t1_wstrb", 64'(mem_wstrb), 64'hF);
      chk("t1_idle_req", 64'(mem_req), 64'd0);

      // Five completions into a four-slot ring
      do_reset();
      comp_base = 64'h500; comp_mask = 32'h3; enable = 1'b1;
      for (int i = 1; i <= 5; i++)
         push(32'(i), 16'(16'h00A0 + i), 16'(16'hB000 + i), 32'(32'h10 * i));
      wait_msgs(5, "t2_msgs");
      chk("t2_nwr", 64'(la.size()), 64'd20);
      chk_wr(4,  64'h510, 32'd2,         "t2_tag2");
      chk_wr(9,  64'h524, 32'hB00300A3,  "t2_st3");
      chk_wr(12, 64'h530, 32'd4,         "t2_tag4");
      chk_wr(16, 64'h500, 32'd5,         "t2_tag5_wrap");
      chk_wr(17, 64'h504, 32'hB00500A5,  "t2_st5");
      chk_wr(18, 64'h508, 32'h50,        "t2_bytes5");
      chk("t2_idx", 64'(comp_idx), 64'd5);

      // Stall in W1, base/mask changed mid-record, backpressure
      do_reset();
      comp_base = 64'h500; comp_mask = 32'h3; enable = 1'b1; stall_w1 = 1'b1;
      push(32'h11, 16'h1234, 16'hABCD, 32'h40);
      wait_addr(64'h504, "t3_reach_w1");
      fork
         begin
            @(posedge clk); #1;
            comp_base = 64'h900; comp_mask = 32'h0;
            push(32'h22, 16'h2, 16'h3, 32'h80);
         end
         begin
            chk("t3_hold_addr", mem_addr, 64'h504);
            chk("t3_hold_data", 64'(mem_wdata), 64'hABCD1234);
            for (int i = 0; i < 9; i++) begin
               @(negedge clk);
               chk("t3_hold_addr", mem_addr, 64'h504);
               chk("t3_hold_data", 64'(mem_wdata), 64'hABCD1234);
            end
         end
      join
      @(negedge clk);
      chk("t3_ready_full", 64'(comp_ready), 64'd0);
      chk("t3_still_req", 64'(mem_req), 64'd1);
      fork
         begin
            push(32'h33, 16'h5, 16'h6, 32'hC0);
            push(32'h44, 16'h7, 16'h8, 32'h100);
         end
         begin
            repeat (4) @(negedge clk);
            chk("t3_ready_held", 64'(comp_ready), 64'd0);
            @(posedge clk); #1 stall_w1 = 1'b0;
         end
      join
      wait_msgs(4, "t3_msgs");
      chk("t3_nwr", 64'(la.size()), 64'd16);
      chk_wr(1,  64'h504, 32'hABCD1234, "t3_r1_w1");
      chk_wr(2,  64'h508, 32'h40,       "t3_r1_w2");
      chk_wr(4,  64'h900, 32'h22,       "t3_r2");
      chk_wr(8,  64'h900, 32'h33,       "t3_r3");
      chk_wr(12, 64'h900, 32'h44,       "t3_r4");
      chk("t3_idx", 64'(comp_idx), 64'd4);

      // Enable gating: no start while low, record in flight finishes
      do_reset();
      comp_base = 64'h500; comp_mask = 32'h3; enable = 1'b0;
      push(32'h70, 16'h1, 16'h2, 32'h3);
      push(32'h71, 16'h4, 16'h5, 32'h6);
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen = seen | mem_req;
      end
      chk("t4_no_start", 64'(seen), 64'd0);
      @(posedge clk); #1 enable = 1'b1;
      wait_addr(64'h504, "t4_reach_w1");
      @(posedge clk); #1 enable = 1'b0;
      @(negedge clk);
      chk("t4_drop_in_w2", mem_addr, 64'h508);
      wait_msgs(1, "t4_msgs1");
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen = seen | mem_req;
      end
      chk("t4_no_restart", 64'(seen), 64'd0);
      chk("t4_nwr", 64'(la.size()), 64'd4);
      chk("t4_idx", 64'(comp_idx), 64'd1);
      @(posedge clk); #1 enable = 1'b1;
      wait_msgs(2, "t4_msgs2");
      chk_wr(4, 64'h510, 32'h71, "t4_r2");

      // Reset in the middle of W2
      do_reset();
      comp_base = 64'h500; comp_mask = 32'h0; enable = 1'b1;
      push(32'h99, 16'h1, 16'h1, 32'h1);
      wait_addr(64'h508, "t5_reach_w2");
      m = msg_cnt;
      #2 rst = 1'b1;
      #1;
      chk("t5_req_low",   64'(mem_req),    64'd0);
      chk("t5_ready_low", 64'(comp_ready), 64'd0);
      chk("t5_msg_low",   64'(comp_msg),   64'd0);
      chk("t5_idx",       64'(comp_idx),   64'd0);
      chk("t5_addr",      mem_addr,        64'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("t5_ready_up", 64'(comp_ready), 64'd1);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen = seen | mem_req;
      end
      chk("t5_fifo_empty", 64'(seen), 64'd0);
      chk("t5_no_msg", 64'(msg_cnt), 64'(m));
      chk("t5_idx_after", 64'(comp_idx), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
      $finish;
   end

endmodule
